pmod_i2c_byte_engine: RTL

Byte-level I2C master engine that executes one START, STOP, WRITE or READ command per strobe and generates the open-drain SCL/SDA waveforms for the `eurorack-pmod` I2C bus. It sits directly downstream of the PMOD I2C sequencer, which issues commands to this block. The block supports clock stretching and arbitration-loss detection. It returns per-byte ACK status and read data to the sequencer.

---
 rtl/pmod_i2c_byte_engine.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pmod_i2c_byte_engine.sv
// pmod_i2c_byte_engine: byte-level I2C master engine for the eurorack-pmod bus.
// Each strobe runs one START, STOP, WRITE or READ command. The engine drives
// the open-drain SCL/SDA lines, honours clock stretching and detects
// arbitration loss.
// Optional build macro PMOD_I2C_STRETCH_TIMEOUT_EN: a 16-bit counter aborts
// the command after 65535 consecutive cycles spent waiting for SCL to go high.
// Without the macro the engine waits for SCL indefinitely.
// DW must be at least 1, so that the SDA sample at the start of q2 never
// lands on the last cycle of that quarter.
module pmod_i2c_byte_engine #(
  parameter int DW = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       scl_oe,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i,
  input  logic [1:0] cmd,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  input  logic       stb,
  output logic [7:0] data_out,
  output logic       ack_out,
  output logic       err_out,
  output logic       ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_STOP,
    S_BIT
  } state_e;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_e        state_q;
  logic [1:0]    qtr_q;       // quarter within the current START/STOP/bit
  logic [3:0]    bit_q;       // bit index 0..8 within a byte command
  logic [DW-1:0] cnt_q;       // cycle counter within a quarter
  logic [DW-1:0] cnt_d;
  logic          rd_q;        // 1 = READ, 0 = WRITE (BIT state only)
  logic [7:0]    tx_q;        // WRITE shift register, tx_q[7] is the current bit
  logic [7:0]    rx_q;        // READ shift register
  logic          ack_in_q;
  logic          scl_oe_q;
  logic          sda_oe_q;
  logic [7:0]    data_out_q;
  logic          ack_out_q;
  logic          err_q;
  logic          ready_q;

  logic accept;
  logic stall;
  logic qtr_end;
  logic sample;
  logic arb_lost;
  logic timeout;

  // Handshake, stretch detection, quarter timing and arbitration check
  always_comb begin
    accept   = stb && ready_q;
    // A released SCL still read low means a slave is stretching the clock
    stall    = (state_q != S_IDLE) && !scl_oe_q && !scl_i;
    qtr_end  = (cnt_q == {DW{1'b1}}) && !stall;
    // First cycle of q2 that actually sees SCL high
    sample   = (state_q == S_BIT) && (qtr_q == 2'd2) && (cnt_q == '0) && !stall;
    // We released SDA for a data bit but somebody else holds it low
    arb_lost = sample && !rd_q && (bit_q != 4'd8) && !sda_oe_q && !sda_i;
    cnt_d    = stall ? cnt_q : cnt_q + 1'b1;
  end

`ifdef PMOD_I2C_STRETCH_TIMEOUT_EN
  logic [15:0] stretch_q;
  logic [15:0] stretch_d;

  // Abort on the 65535th consecutive stretch cycle
  always_comb begin
    timeout   = stall && (stretch_q == 16'hFFFE);
    stretch_d = stall ? stretch_q + 16'd1 : 16'd0;
  end

  // Count consecutive cycles spent waiting for SCL to rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stretch_q <= 16'd0;
    end else begin
      stretch_q <= stretch_d;
    end
  end
`else
  // No stretch limit: wait for SCL indefinitely
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Command FSM with registered line drivers and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      qtr_q      <= 2'd0;
      bit_q      <= 4'd0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      tx_q       <= 8'd0;
      rx_q       <= 8'd0;
      ack_in_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      data_out_q <= 8'd0;
      ack_out_q  <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            qtr_q    <= 2'd0;
            bit_q    <= 4'd0;
            tx_q     <= data_in;
            rd_q     <= cmd[0];
            ack_in_q <= ack_in;
            // q0 line levels take effect on the first cycle of the command
            case (cmd)
              CMD_START: begin
                state_q  <= S_START;
                sda_oe_q <= 1'b0;
              end
              CMD_STOP: begin
                // Also pulls SCL low when STOP is issued from an idle bus
                state_q  <= S_STOP;
                sda_oe_q <= 1'b1;
                scl_oe_q <= 1'b1;
              end
              CMD_WRITE: begin
                state_q  <= S_BIT;
                sda_oe_q <= ~data_in[7];
              end
              default: begin
                state_q  <= S_BIT;
                sda_oe_q <= 1'b0;
              end
            endcase
          end
        end

        default: begin
          if (arb_lost || timeout) begin
            // Abort: hand the bus back and report the error
            state_q  <= S_IDLE;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            err_q    <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;

            if (sample) begin
              if (rd_q && (bit_q != 4'd8)) begin
                rx_q <= {rx_q[6:0], sda_i};
              end else if (!rd_q && (bit_q == 4'd8)) begin
                ack_out_q <= sda_i;
              end
            end

            if (qtr_end) begin
              qtr_q <= qtr_q + 2'd1;
              case (state_q)
                S_START: begin
                  case (qtr_q)
                    2'd0:    scl_oe_q <= 1'b0;
                    2'd1:    sda_oe_q <= 1'b1;
                    2'd2:    scl_oe_q <= 1'b1;
                    default: begin
                      state_q <= S_IDLE;
                      ready_q <= 1'b1;
                    end
                  endcase
                end

                S_STOP: begin
                  case (qtr_q)
                    2'd0:    scl_oe_q <= 1'b0;
                    2'd1:    sda_oe_q <= 1'b0;
                    2'd2:    ;  // q3 is the bus-free hold
                    default: begin
                      state_q <= S_IDLE;
                      ready_q <= 1'b1;
                    end
                  endcase
                end

                default: begin
                  case (qtr_q)
                    2'd0:    scl_oe_q <= 1'b0;
                    2'd1:    ;  // SCL high, sample happens at q2 start
                    2'd2:    scl_oe_q <= 1'b1;
                    default: begin
                      if (bit_q == 4'd8) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        if (rd_q) begin
                          data_out_q <= rx_q;
                        end
                      end else begin
                        bit_q <= bit_q + 4'd1;
                        tx_q  <= {tx_q[6:0], 1'b0};
                        // Set up SDA for the next bit while SCL is low
                        if (bit_q == 4'd7) begin
                          sda_oe_q <= rd_q ? ~ack_in_q : 1'b0;
                        end else begin
                          sda_oe_q <= rd_q ? 1'b0 : ~tx_q[6];
                        end
                      end
                    end
                  endcase
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign data_out = data_out_q;
  assign ack_out  = ack_out_q;
  assign err_out  = err_q;
  assign ready    = ready_q;

endmodule
